// File: rtl/alu.sv
// Eight-operation ALU (add/sub/logic/shift) with a registered C/N/P/Z flag unit.
// Latency: busC is combinational (0 cycles); flags are visible 1 cycle after the operands.
// Backpressure: none; a new operation is accepted every cycle, and enaf=0 holds the flags.
module alu #(
  parameter int MAX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enaf,
  input  logic [2:0]           selop,
  input  logic [1:0]           shamt,
  input  logic [MAX_WIDTH-1:0] busA,
  input  logic [MAX_WIDTH-1:0] busB,
  output logic [MAX_WIDTH-1:0] busC,
  output logic                 C,
  output logic                 N,
  output logic                 P,
  output logic                 Z
);

  localparam int W = MAX_WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  // Condition flags kept together so hold/load/reset treat them as one word.
  typedef struct packed {
    logic c;
    logic n;
    logic p;
    logic z;
  } flags_t;

  // Arithmetic and shift paths are one bit wider than the operands; the
  // extra bit carries the carry/borrow or the last bit shifted out.
  logic [W:0] add_ext;
  logic [W:0] sub_ext;
  logic [W:0] shl_ext;
  logic [W:0] shr_ext;

  logic [W-1:0] result;
  logic         carry_raw;
  op_e          op;

  flags_t flags_nxt;
  flags_t flags_d;
  flags_t flags_q;

  assign op = op_e'(selop);

  // Wide datapaths: SUB uses A + ~B + 1 so its carry-out means "no borrow".
  // SHL pushes the last departing bit into bit W; SHR shifts A placed one
  // bit up so the last departing bit lands in bit 0. A zero shift leaves
  // the carry slot at zero in both cases.
  always_comb begin
    add_ext = {1'b0, busA} + {1'b0, busB};
    sub_ext = {1'b0, busA} + {1'b0, ~busB} + (W+1)'(1);
    shl_ext = {1'b0, busA} << shamt;
    shr_ext = {busA, 1'b0} >> shamt;
  end

  // Operation select: result and the raw carry for the selected opcode.
  always_comb begin
    result    = '0;
    carry_raw = 1'b0;
    unique case (op)
      OP_ADD: begin
        result    = add_ext[W-1:0];
        carry_raw = add_ext[W];
      end
      OP_SUB: begin
        result    = sub_ext[W-1:0];
        carry_raw = sub_ext[W];
      end
      OP_AND: result = busA & busB;
      OP_OR:  result = busA | busB;
      OP_XOR: result = busA ^ busB;
      OP_NOT: result = ~busA;
      OP_SHL: begin
        result    = shl_ext[W-1:0];
        carry_raw = shl_ext[W];
      end
      OP_SHR: begin
        result    = shr_ext[W:1];
        carry_raw = shr_ext[0];
      end
      default: begin
        result    = '0;
        carry_raw = 1'b0;
      end
    endcase
  end

  assign busC = result;

  // Next flags from the live result; N, Z and P are mutually exclusive.
  always_comb begin
    flags_nxt   = '0;
    flags_nxt.c = carry_raw;
    flags_nxt.n = result[W-1];
    flags_nxt.z = (result == '0);
    flags_nxt.p = ~flags_nxt.n & ~flags_nxt.z;
  end

  // Flag write enable: load the next flags or hold the current ones.
  always_comb begin
    flags_d = flags_q;
    if (enaf) begin
      flags_d = flags_nxt;
    end
  end

  // Flag register; reset wins over enaf and clears all four flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign C = flags_q.c;
  assign N = flags_q.n;
  assign P = flags_q.p;
  assign Z = flags_q.z;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu at widths 8 and 16 driven with identical control.
// Latency: busC checked mid-cycle, flags checked just after the following edge.
// Backpressure: none; one operation per cycle.
module tb_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enaf;
  logic [2:0]  selop;
  logic [1:0]  shamt;
  logic [7:0]  a8, b8, c8;
  logic [15:0] a16, b16, c16;
  logic        C8, N8, P8, Z8;
  logic        C16, N16, P16, Z16;

  alu #(.MAX_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enaf(enaf), .selop(selop), .shamt(shamt),
    .busA(a8), .busB(b8), .busC(c8),
    .C(C8), .N(N8), .P(P8), .Z(Z8)
  );

  alu #(.MAX_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .enaf(enaf), .selop(selop), .shamt(shamt),
    .busA(a16), .busB(b16), .busC(c16),
    .C(C16), .N(N16), .P(P16), .Z(Z16)
  );

  typedef struct {
    int          id;
    logic [15:0] c8;
    logic [15:0] c16;
    logic [3:0]  f8;
    logic [3:0]  f16;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_steps  = 0;

  // Reference flag state {C,N,P,Z} for each width.
  logic [3:0] mf8  = 4'h0;
  logic [3:0] mf16 = 4'h0;

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Arithmetic reference: unsigned integer math modulo 2^w.
  function automatic void ref_op(input int w, input int op, input int s, input int a, input int b,
                                 output int res, output int cy);
    int m;
    m  = 1 << w;
    cy = 0;
    case (op)
      0: begin res = (a + b) % m; cy = ((a + b) >= m) ? 1 : 0; end
      1: begin res = (a - b + m) % m; cy = (a >= b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = m - 1 - a;
      6: begin
        res = (a << s) % m;
        if (s > 0) cy = (a >> (w - s)) & 1;
      end
      default: begin
        res = a >> s;
        if (s > 0) cy = (a >> (s - 1)) & 1;
      end
    endcase
  endfunction

  function automatic logic [3:0] flags_of(input int w, input int res, input int cy);
    int n, z, p;
    n = (res >> (w - 1)) & 1;
    z = (res == 0) ? 1 : 0;
    p = (n == 0 && z == 0) ? 1 : 0;
    return 4'(cy * 8 + n * 4 + p * 2 + z);
  endfunction

  // Apply one operation, predict busC and post-edge flags, then advance one edge.
  task automatic step(input logic r, input logic e, input int op, input int s,
                      input int av8, input int bv8, input int av16, input int bv16);
    exp_t it;
    int   r8, cy8, r16, cy16;
    rst   = r;
    enaf  = e;
    selop = 3'(op);
    shamt = 2'(s);
    a8    = 8'(av8);
    b8    = 8'(bv8);
    a16   = 16'(av16);
    b16   = 16'(bv16);
    ref_op(8,  op, s, av8 & 'hFF,    bv8 & 'hFF,    r8,  cy8);
    ref_op(16, op, s, av16 & 'hFFFF, bv16 & 'hFFFF, r16, cy16);
    if (!r) begin
      mf8  = 4'h0;
      mf16 = 4'h0;
    end else if (e) begin
      mf8  = flags_of(8,  r8,  cy8);
      mf16 = flags_of(16, r16, cy16);
    end
    it.id  = n_steps;
    it.c8  = 16'(r8);
    it.c16 = 16'(r16);
    it.f8  = mf8;
    it.f16 = mf16;
    sb.push_back(it);
    n_steps++;
    @(posedge clk);
    #2;
  endtask

  // Monitor: busC mid-cycle, then the flags just after the capturing edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("busC_w8",  it.id, {8'h00, c8}, it.c8);
        chk("busC_w16", it.id, c16, it.c16);
        @(posedge clk);
        #1;
        chk("flags_w8",  it.id, {12'h000, C8, N8, P8, Z8},     {12'h000, it.f8});
        chk("flags_w16", it.id, {12'h000, C16, N16, P16, Z16}, {12'h000, it.f16});
      end
    end
  end

  initial begin
    int op, s, wait_cyc;
    rst   = 1'b0;
    enaf  = 1'b0;
    selop = 3'd0;
    shamt = 2'd0;
    a8    = '0;
    b8    = '0;
    a16   = '0;
    b16   = '0;
    @(posedge clk);
    #2;

    // Reset dominates enaf, then first released edge loads normal flags.
    step(1'b0, 1'b1, 0, 0, 'hFF, 'h01, 'hFFFF, 'h0001);
    step(1'b1, 1'b1, 0, 0, 'hFF, 'h01, 'hFFFF, 'h0001);
    // Arithmetic.
    step(1'b1, 1'b1, 0, 0, 'h26, 'hFF, 'h1234, 'hFFFF);
    step(1'b1, 1'b1, 1, 0, 'hEB, 'h55, 'h00EB, 'h0055);
    step(1'b1, 1'b1, 1, 0, 'h00, 'h55, 'h0000, 'h0055);
    step(1'b1, 1'b1, 0, 3, 'h7F, 'h01, 'h7FFF, 'h0001);
    // Logic.
    step(1'b1, 1'b1, 2, 0, 'hEB, 'h55, 'hF0EB, 'h0F55);
    step(1'b1, 1'b1, 3, 0, 'hEB, 'h55, 'h80EB, 'h0055);
    step(1'b1, 1'b1, 4, 0, 'hFF, 'h55, 'hFFFF, 'h5555);
    step(1'b1, 1'b1, 5, 2, 'hFF, 'h12, 'hFFFF, 'h1234);
    // Shifts.
    step(1'b1, 1'b1, 6, 1, 'hEB, 'h00, 'h80EB, 'h0000);
    step(1'b1, 1'b1, 7, 2, 'hEB, 'h00, 'h00EB, 'h0000);
    step(1'b1, 1'b1, 7, 0, 'h80, 'h00, 'h8000, 'h0000);
    step(1'b1, 1'b1, 6, 3, 'hFF, 'h00, 'hFFFF, 'h0000);
    step(1'b1, 1'b1, 6, 0, 'h81, 'h00, 'h8001, 'h0000);
    // Enable hold: Z set, then three edges with enaf low.
    step(1'b1, 1'b1, 0, 0, 'h00, 'h00, 'h0000, 'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1, 0, 'hEB, 'h55, 'h00EB, 'h0055);
    end

    // Randomized traffic with occasional reset and enable gaps.
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      s  = int'($urandom_range(0, 3));
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), op, s,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    repeat (2) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Parameterized combinational ALU with a registered condition-flag unit for the datapath execute stage. Computes one of eight arithmetic, logic or shift operations on two operand buses and drives the result combinationally on `busC`. Carry, negative, positive and zero flags are captured on the clock edge when flag update is enabled. Downstream branch and condition logic reads these flags.

## Interface
- `MAX_WIDTH`, default 8: operand and result width in bits; must be ≥ 2.

- `clk`  in  1: single clock; flags update on the rising edge.
- `rst`  in  1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `enaf`  in  1: flag-register write enable.
- `selop`  in  3: operation select.
- `shamt`  in  2: shift amount (0–3), used only by shift ops.
- `busA`  in  `MAX_WIDTH`: operand A.
- `busB`  in  `MAX_WIDTH`: operand B.
- `busC`  out  `MAX_WIDTH`: result, combinational.
- `C`  out  1: registered carry flag.
- `N`  out  1: registered negative flag.
- `P`  out  1: registered positive flag.
- `Z`  out  1: registered zero flag.

## Operation
All operands are unsigned bit vectors. "Next flags" are computed combinationally from the current `busC` and raw carry.

Opcode map:
- 000 ADD: busC = A+B mod 2^W; carry = carry-out of bit W-1.
- 001 SUB: busC = A−B mod 2^W, computed as A + ~B + 1; carry = 1 when no borrow (A ≥ B unsigned).
- 010 AND: busC = A & B; carry = 0.
- 011 OR: busC = A | B; carry = 0.
- 100 XOR: busC = A ^ B; carry = 0.
- 101 NOT: busC = ~A; `busB` ignored; carry = 0.
- 110 SHL: busC = A << shamt (zero fill); carry = last bit shifted out, i.e. A[W−shamt]; carry = 0 when shamt = 0.
- 111 SHR: busC = A >> shamt (logical, zero fill); carry = A[shamt−1]; carry = 0 when shamt = 0.
- `shamt` is ignored by opcodes 000–101.

Flag rules:
- Next N = busC[W−1].
- Next Z = (busC == 0).
- Next P = ~N & ~Z. Exactly one of N, Z, P is 1 after any update.
- Next C = carry per the opcode map.

## Timing
- `busC` has zero latency: it is purely combinational from `busA`, `busB`, `selop` and `shamt`. It has no reset value and is unaffected by `rst` and `enaf`.
- Rising edge of `clk`, in priority order:
  - `rst`=0: C=N=P=Z=0, regardless of `enaf`.
  - else if `enaf`=1: C, N, P, Z take their next values.
  - else: flags hold.
- Flags reflect the operation present at the capturing edge and are visible one cycle after the operands are applied.
- Reset values: C=0, N=0, P=0, Z=0. The all-zero state is only reachable via reset.
- Deasserting reset mid-operation: the first edge with `rst`=1 and `enaf`=1 loads normal flags. No further recovery cycle.
- Inputs changing between edges: `busC` follows immediately; flags never glitch.

## Test plan
- Reset: `rst`=0, `enaf`=1, ADD 0xFF+0x01, one edge → C=N=P=Z=0 while `busC`=0x00. Then `rst`=1, one edge → C=1, Z=1, N=0, P=0.
- ADD/SUB at W=8:
  - ADD 0x26+0xFF → busC=0x25, C=1, P=1.
  - SUB 0xEB−0x55 → busC=0x96, C=1, N=1.
  - SUB 0x00−0x55 → busC=0xAB, C=0, N=1.
- Logic:
  - AND 0xEB,0x55 → 0x41, P=1, C=0.
  - OR 0xEB,0x55 → 0xFF, N=1.
  - XOR 0xFF,0x55 → 0xAA, N=1.
  - NOT 0xFF → 0x00, Z=1, C=0.
- Shifts:
  - SHL 0xEB by 1 → 0xD6, C=1, N=1.
  - SHR 0xEB by 2 → 0x3A, C=1, P=1.
  - SHR 0x80 by 0 → 0x80, C=0, N=1.
  - SHL 0xFF by 3 → 0xF8, C=1.
- Enable hold: set flags via ADD 0x00+0x00 (Z=1). Then `enaf`=0 with SUB 0xEB−0x55 for 3 edges → `busC`=0x96 immediately, flags remain Z=1, C=0, N=0, P=0.
- Width: MAX_WIDTH=16, ADD 0xFFFF+0x0001 → busC=0x0000, C=1, Z=1.
